// File: rtl/clk_cmd_writer.sv
// Command-frame writer: parses A5/ADDR/DATA/CSUM frames and strobes one wcmd line with cmd held stable.
// Optional build macro CLK_CMD_TIMEOUT_EN enables the inter-byte timeout inside a frame.
module clk_cmd_writer #(
    parameter int NUM_TARGETS = 4,
    parameter int STROBE_LEN  = 4,
    parameter int TIMEOUT     = 1023
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    output logic [7:0]             cmd,
    output logic [NUM_TARGETS-1:0] wcmd,
    output logic                   busy,
    output logic                   err,
    output logic [2:0]             o_dbg_state
);

    typedef enum logic [2:0] {
        S_HUNT   = 3'd0,
        S_ADDR   = 3'd1,
        S_DATA   = 3'd2,
        S_CSUM   = 3'd3,
        S_SETUP  = 3'd4,
        S_STROBE = 3'd5,
        S_HOLD   = 3'd6
    } state_t;

    localparam logic [7:0] LP_SYNC    = 8'hA5;
    localparam logic [7:0] LP_NT      = 8'(NUM_TARGETS);
    localparam logic [7:0] LP_SL_LAST = 8'(STROBE_LEN - 1);

    if (NUM_TARGETS < 1 || NUM_TARGETS > 16 || STROBE_LEN < 1 || STROBE_LEN > 255 ||
        TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_params
        $error("clk_cmd_writer: parameter out of legal range");
    end

    state_t                   r_state, w_state_nxt;
    logic [7:0]               r_addr, w_addr_nxt;
    logic [7:0]               r_data, w_data_nxt;
    logic [7:0]               r_cmd, w_cmd_nxt;
    logic [NUM_TARGETS-1:0]   r_wcmd, w_wcmd_nxt;
    logic                     r_err, w_err_nxt;
    logic [7:0]               r_cnt, w_cnt_nxt;
    logic [NUM_TARGETS-1:0]   w_onehot;
    logic                     w_rx_ready;
    logic                     w_accept;
    logic                     w_csum_ok;
`ifdef CLK_CMD_TIMEOUT_EN
    localparam logic [15:0]   LP_TO_LAST = 16'(TIMEOUT - 1);
    logic [15:0]              r_to, w_to_nxt;
`endif

    // Handshake: a byte moves on a rising CLK edge where rx_valid && rx_ready; rx_ready depends on state only.
    assign w_rx_ready = (r_state == S_HUNT) || (r_state == S_ADDR) ||
                        (r_state == S_DATA) || (r_state == S_CSUM);
    assign w_accept   = rx_valid && w_rx_ready;
    assign w_csum_ok  = (rx_data == (r_addr ^ r_data)) && (r_addr < LP_NT);

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            w_onehot[i] = (r_addr == 8'(i));
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_cmd_nxt   = r_cmd;
        w_wcmd_nxt  = r_wcmd;
        w_err_nxt   = 1'b0;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_HUNT: begin
                if (w_accept && rx_data == LP_SYNC) w_state_nxt = S_ADDR;
            end
            S_ADDR: begin
                if (w_accept) begin
                    w_addr_nxt  = rx_data;
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_accept) begin
                    w_data_nxt  = rx_data;
                    w_state_nxt = S_CSUM;
                end
            end
            S_CSUM: begin
                if (w_accept) begin
                    if (w_csum_ok) begin
                        w_cmd_nxt   = r_data;
                        w_state_nxt = S_SETUP;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_HUNT;
                    end
                end
            end
            S_SETUP: begin
                w_wcmd_nxt  = w_onehot;
                w_cnt_nxt   = '0;
                w_state_nxt = S_STROBE;
            end
            S_STROBE: begin
                if (r_cnt == LP_SL_LAST) begin
                    w_wcmd_nxt  = '0;
                    w_state_nxt = S_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            S_HOLD:  w_state_nxt = S_HUNT;
            default: w_state_nxt = S_HUNT;
        endcase
`ifdef CLK_CMD_TIMEOUT_EN
        // Idle time is only measured while a frame is partially received.
        w_to_nxt = '0;
        if ((r_state == S_ADDR || r_state == S_DATA || r_state == S_CSUM) && !w_accept) begin
            if (r_to == LP_TO_LAST) begin
                w_err_nxt   = 1'b1;
                w_state_nxt = S_HUNT;
            end else begin
                w_to_nxt = r_to + 16'd1;
            end
        end
`endif
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= S_HUNT;
            r_addr  <= '0;
            r_data  <= '0;
            r_cmd   <= '0;
            r_wcmd  <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
`ifdef CLK_CMD_TIMEOUT_EN
            r_to    <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
            r_cmd   <= w_cmd_nxt;
            r_wcmd  <= w_wcmd_nxt;
            r_err   <= w_err_nxt;
            r_cnt   <= w_cnt_nxt;
`ifdef CLK_CMD_TIMEOUT_EN
            r_to    <= w_to_nxt;
`endif
        end
    end

    assign rx_ready    = w_rx_ready;
    assign busy        = (r_state == S_SETUP) || (r_state == S_STROBE) || (r_state == S_HOLD);
    assign cmd         = r_cmd;
    assign wcmd        = r_wcmd;
    assign err         = r_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_clk_cmd_writer.sv
// Bench for clk_cmd_writer: timeline reference model checked every cycle, directed frames and random traffic.
// Honours CLK_CMD_TIMEOUT_EN the same way as the design.
module tb_clk_cmd_writer;

    localparam int NT = 4;
    localparam int SL = 4;
    localparam int TO = 16;

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic [7:0]    cmd;
    logic [NT-1:0] wcmd;
    logic          busy;
    logic          err;
    logic [2:0]    o_dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    clk_cmd_writer #(.NUM_TARGETS(NT), .STROBE_LEN(SL), .TIMEOUT(TO)) dut (
        .CLK(CLK), .nRST(nRST), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .cmd(cmd), .wcmd(wcmd), .busy(busy), .err(err), .o_dbg_state(o_dbg_state)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: byte queue for the frame and a timeline keyed on the write edge
    int         c = 0;
    int         wr_edge = -100;
    int         err_edge = -1;
    int         idle = 0;
    logic [7:0] m_cmd = 8'h00;
    logic [7:0] m_addr = 8'h00;
    logic [7:0] m_buf[$];

    function automatic logic m_ready(input int cc);
        return !(cc >= wr_edge && cc <= wr_edge + 1 + SL);
    endfunction

    always @(posedge CLK) begin
        if (!nRST) begin
            c = 0; wr_edge = -100; err_edge = -1; idle = 0; m_cmd = 8'h00; m_buf.delete();
        end else begin
            logic rdy;
            rdy = m_ready(c);
            c++;
            if (rx_valid && rdy) begin
                idle = 0;
                if (m_buf.size() != 0 || rx_data == 8'hA5) m_buf.push_back(rx_data);
                if (m_buf.size() == 4) begin
                    if (m_buf[3] == (m_buf[1] ^ m_buf[2]) && m_buf[1] < NT) begin
                        wr_edge = c; m_addr = m_buf[1]; m_cmd = m_buf[2];
                    end else begin
                        err_edge = c;
                    end
                    m_buf.delete();
                end
            end else if (m_buf.size() != 0) begin
`ifdef CLK_CMD_TIMEOUT_EN
                idle++;
                if (idle == TO) begin
                    err_edge = c; idle = 0; m_buf.delete();
                end
`endif
            end
        end
    end

    // scoreboard compare, every cycle out of reset
    always @(negedge CLK) begin
        if (nRST) begin
            logic [NT-1:0] ew;
            logic [1:0]    a2;
            a2 = m_addr[1:0];
            ew = (c >= wr_edge + 1 && c <= wr_edge + SL) ? (NT'(1) << a2) : '0;
            chk("cyc_cmd", 32'(cmd), 32'(m_cmd));
            chk("cyc_wcmd", 32'(wcmd), 32'(ew));
            chk("cyc_err", 32'(err), 32'(c == err_edge));
            chk("cyc_ready", 32'(rx_ready), 32'(m_ready(c)));
            chk("cyc_busy", 32'(busy), 32'(!m_ready(c)));
        end
    end

    // driver tasks (called at a falling edge, return at a falling edge)
    task automatic send_byte(input logic [7:0] b);
        int k;
        k = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && k < 200) begin
            @(negedge CLK);
            k++;
        end
        if (k >= 200) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: rx_ready stuck low for byte %0h", b);
        end
        @(posedge CLK);
        @(negedge CLK);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b0, b1, b2, b3);
        send_byte(b0); send_byte(b1); send_byte(b2); send_byte(b3);
    endtask

    int         w_hi, w_nr, w_errs, w_rises, w_err0;
    logic [7:0] w_cmd_pre;
    logic [NT-1:0] w_first;

    task automatic watch(input int n);
        logic [NT-1:0] prev_w;
        logic [7:0]    prev_c;
        w_hi = 0; w_nr = 0; w_errs = 0; w_rises = 0; w_err0 = int'(err);
        w_first = '0; w_cmd_pre = 8'h00;
        prev_w = wcmd; prev_c = cmd;
        for (int i = 0; i < n; i++) begin
            if (wcmd != 0) w_hi++;
            if (!rx_ready) w_nr++;
            if (err) w_errs++;
            if (wcmd != 0 && prev_w == 0) begin
                w_rises++;
                if (w_rises == 1) begin w_first = wcmd; w_cmd_pre = prev_c; end
            end
            prev_w = wcmd; prev_c = cmd;
            @(negedge CLK);
        end
    endtask

    initial begin
        #2_000_000;
        n_checks++; n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        repeat (3) @(negedge CLK);
        chk("rst_cmd", 32'(cmd), 32'h00);
        chk("rst_wcmd", 32'(wcmd), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ready", 32'(rx_ready), 32'h1);
        nRST = 1'b1;
        repeat (2) @(negedge CLK);

        send_frame(8'hA5, 8'h01, 8'h03, 8'h02);
        watch(12);
        chk("f1_cmd_before_rise", 32'(w_cmd_pre), 32'h03);
        chk("f1_wcmd", 32'(w_first), 32'b0010);
        chk("f1_hi_cycles", 32'(w_hi), 32'd4);
        chk("f1_notready_cycles", 32'(w_nr), 32'd6);
        chk("f1_errs", 32'(w_errs), 32'd0);

        send_frame(8'hA5, 8'h00, 8'h55, 8'h54);
        watch(4);
        chk("badcs_err_now", 32'(w_err0), 32'd1);
        chk("badcs_errs", 32'(w_errs), 32'd1);
        chk("badcs_rises", 32'(w_rises), 32'd0);
        chk("badcs_cmd", 32'(cmd), 32'h03);
        send_frame(8'hA5, 8'h00, 8'h55, 8'h55);
        watch(12);
        chk("f2_wcmd", 32'(w_first), 32'b0001);
        chk("f2_cmd_before_rise", 32'(w_cmd_pre), 32'h55);

        send_frame(8'hA5, 8'h04, 8'h10, 8'h14);
        watch(4);
        chk("oor_errs", 32'(w_errs), 32'd1);
        chk("oor_rises", 32'(w_rises), 32'd0);

        send_byte(8'h00); send_byte(8'hFF);
        send_frame(8'hA5, 8'h02, 8'h81, 8'h83);
        watch(12);
        chk("garb_rises", 32'(w_rises), 32'd1);
        chk("garb_wcmd", 32'(w_first), 32'b0100);
        chk("garb_cmd", 32'(w_cmd_pre), 32'h81);

        send_frame(8'hA5, 8'hA5, 8'h00, 8'hA5);
        watch(4);
        chk("a5addr_errs", 32'(w_errs), 32'd1);
        chk("a5addr_rises", 32'(w_rises), 32'd0);

        send_byte(8'hA5); send_byte(8'h01);
        watch(20);
`ifdef CLK_CMD_TIMEOUT_EN
        chk("to_errs", 32'(w_errs), 32'd1);
`else
        chk("to_errs", 32'(w_errs), 32'd0);
`endif
        send_byte(8'h07); send_byte(8'h06);
        watch(12);
`ifdef CLK_CMD_TIMEOUT_EN
        chk("late_rises", 32'(w_rises), 32'd0);
`else
        chk("late_rises", 32'(w_rises), 32'd1);
        chk("late_wcmd", 32'(w_first), 32'b0010);
        chk("late_cmd", 32'(w_cmd_pre), 32'h07);
`endif

        for (int i = 0; i < 300; i++) begin
            logic [7:0] a, d, x;
            int kind;
            kind = $urandom_range(0, 4);
            a = 8'($urandom_range(0, NT - 1));
            d = 8'($urandom_range(0, 255));
            x = 8'($urandom_range(1, 255));
            repeat ($urandom_range(0, 3)) @(negedge CLK);
            case (kind)
                0: send_frame(8'hA5, a, d, a ^ d);
                1: send_frame(8'hA5, a, d, a ^ d ^ x);
                2: begin a = 8'($urandom_range(NT, 255)); send_frame(8'hA5, a, d, a ^ d); end
                3: send_byte((x == 8'hA5) ? 8'h5A : x);
                default: send_frame(8'hA5, 8'hA5, d, 8'hA5 ^ d);
            endcase
        end
        repeat (12) @(negedge CLK);

        send_frame(8'hA5, 8'h02, 8'h77, 8'h75);
        repeat (2) @(negedge CLK);
        chk("rstmid_pre_wcmd", 32'(wcmd), 32'b0100);
        #2 nRST = 1'b0;
        #1;
        chk("rstmid_wcmd", 32'(wcmd), 32'h0);
        chk("rstmid_cmd", 32'(cmd), 32'h00);
        chk("rstmid_ready", 32'(rx_ready), 32'h1);
        chk("rstmid_busy", 32'(busy), 32'h0);
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        send_frame(8'hA5, 8'h03, 8'h09, 8'h0A);
        watch(12);
        chk("post_rst_wcmd", 32'(w_first), 32'b1000);
        chk("post_rst_cmd", 32'(w_cmd_pre), 32'h09);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
